tdc_block_accumulator: RTL
==========================

# tdc_block_accumulator

Parametrised block accumulator for the TDC sample stream. It sums a runtime-selectable power-of-two number of valid samples and emits either the block sum or the rounded block mean, with a one-cycle result strobe. Partial blocks can be flushed on demand. It sits between the TDC sample formatter and the readout/averaging stage.

## Interface
Parameters:
- DATA_W, 16, width of unsigned input samples
- MAX_LOG2_N, 10, largest supported block size exponent; block size N = 2^log2_n
- ACC_W, DATA_W+MAX_LOG2_N, result/accumulator width (derived, not overridden)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_data  in  1  input_signal is valid this cycle
- input_signal  in  DATA_W  unsigned sample
- log2_n  in  $clog2(MAX_LOG2_N+1)  block size exponent; values > MAX_LOG2_N clamp to MAX_LOG2_N
- avg_mode  in  1  0 = output sum, 1 = output rounded mean
- flush  in  1  terminate current block and emit partial result
- result  out  ACC_W  last block result, held until next block
- result_valid  out  1  one-cycle strobe, result updated this cycle
- result_partial  out  1  qualifies result: block ended by flush
- sample_count  out  MAX_LOG2_N+1  samples accepted in current block

## Operation
- Reset: acc, sample_count, result, result_valid, result_partial all 0; cfg registers take log2_n/avg_mode current values on first cycle out of reset.
- Configuration (log2_n clamped, avg_mode) latched into cfg registers whenever sample_count == 0; frozen while a block is open. Mid-block changes take effect on the next block.
- Sample accepted when valid_data == 1: acc <= acc + input_signal, sample_count++.
- Block completion: accepted sample with sample_count == N-1. Same cycle: result register loads f(acc + input_signal), acc <= 0, sample_count <= 0. No dead cycle; a sample on the next cycle starts the new block.
- f(): avg_mode 0 -> sum; avg_mode 1 -> (sum + 2^(k-1)) >> k, k = cfg log2_n, round-half-up, computed in ACC_W+1 bits; k = 0 -> sum unchanged.
- Flush: if sample_count > 0 or valid_data, emit raw sum (including any sample accepted this cycle), result_partial = 1, no division regardless of mode; acc and count cleared. Flush on empty block with no valid sample: ignored, no strobe.
- Flush coinciding with natural completion: treated as natural completion, result_partial = 0.
- Width: ACC_W guarantees no overflow for N ≤ 2^MAX_LOG2_N at max input; no saturation logic.
- Reset asserted mid-block discards acc and count; result and flags cleared; no strobe.

## Timing
- Result latency: result/result_valid registered, visible the cycle after the completing/flush sample edge.
- result_valid high exactly one cycle per block; result and result_partial held until next strobe.
- Max throughput: one sample per cycle, back-to-back blocks with zero gap.
- sample_count registered; reads 0 in the cycle after completion.
- Rounding shifter is combinational from acc+input to result register; single-cycle path.

## Structure
- Package tdc_accum_pkg: ACC_W derivation function, LOG2N_W constant function, avg-mode enum (MODE_SUM, MODE_MEAN).
- Sub-module tdc_round_shift: combinational round-half-up right shift by variable k (ACC_W in, ACC_W out); instantiated once.
- Top holds cfg registers, acc, counter, completion/flush control, output registers.

## Test plan
- log2_n=0, avg_mode=0, samples 5,7 continuous -> two strobes, results 5 then 7, partial=0.
- log2_n=2, avg_mode=0, samples 1,2,3,4 with gaps in valid_data -> one strobe, result 10, one cycle after sample 4.
- log2_n=2, avg_mode=1, samples 1,2,3,4 -> result 3 (10/4=2.5 rounds up); samples 4,4,4,5 -> result 4.
- log2_n=3, 3 samples of 100 then flush -> result 300, partial=1, avg ignored; flush next cycle on empty block -> no strobe.
- MAX_LOG2_N=10, 1024 samples of 0xFFFF, avg_mode=0 -> result 0x3FFFC00, no overflow; back-to-back second block starts without gap.
- log2_n changed 2->1 after 1 sample of block, then rst mid-block -> first block uses N=4; rst clears count and result to 0, no strobe; next block uses N=2.

Source files
------------

// File: rtl/tdc_accum_pkg.sv
// Shared types and width helpers for the TDC block accumulator.
package tdc_accum_pkg;

    // Output selection for a completed block.
    typedef enum logic {
        MODE_SUM  = 1'b0,
        MODE_MEAN = 1'b1
    } avg_mode_e;

    // Accumulator width: enough headroom for 2^max_log2_n full-scale samples.
    function automatic int acc_w(input int data_w, input int max_log2_n);
        return data_w + max_log2_n;
    endfunction

    // Width of the block-size exponent input.
    function automatic int log2n_w(input int max_log2_n);
        return $clog2(max_log2_n + 1);
    endfunction

endpackage

// File: rtl/tdc_round_shift.sv
// Combinational round-half-up right shift: (din + 2^(k-1)) >> k, k = 0 passes din.
module tdc_round_shift #(
    parameter int ACC_W = 26,
    parameter int K_W   = 4
) (
    input  logic [ACC_W-1:0] din,
    input  logic [K_W-1:0]   k,
    output logic [ACC_W-1:0] dout
);

    // One extra bit so the rounding bias cannot wrap before the shift.
    logic [ACC_W:0] half;
    logic [ACC_W:0] biased;

    // Bias by half an LSB of the result, then shift; top bit is always clear after the shift.
    always_comb begin
        half = '0;
        if (k != '0)
            half = (ACC_W+1)'(1) << (k - K_W'(1));
        biased = {1'b0, din} + half;
        dout   = ACC_W'(biased >> k);
    end

endmodule

// File: rtl/tdc_block_accumulator.sv
// Power-of-two block accumulator for the TDC sample stream: emits block sum or
// rounded block mean with a one-cycle strobe; partial blocks can be flushed.
module tdc_block_accumulator
    import tdc_accum_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_LOG2_N = 10,
    parameter int ACC_W      = acc_w(DATA_W, MAX_LOG2_N)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_data,
    input  logic [DATA_W-1:0]                   input_signal,
    input  logic [log2n_w(MAX_LOG2_N)-1:0]      log2_n,
    input  logic                                avg_mode,
    input  logic                                flush,
    output logic [ACC_W-1:0]                    result,
    output logic                                result_valid,
    output logic                                result_partial,
    output logic [MAX_LOG2_N:0]                 sample_count
);

    localparam int LOG2N_W = log2n_w(MAX_LOG2_N);
    localparam int CNT_W   = MAX_LOG2_N + 1;

    logic [ACC_W-1:0]   acc;
    logic [LOG2N_W-1:0] cfg_k;
    avg_mode_e          cfg_mode;

    logic [LOG2N_W-1:0] k_live;
    avg_mode_e          mode_live;
    logic               blk_open;
    logic [LOG2N_W-1:0] k_eff;
    avg_mode_e          mode_eff;
    logic [CNT_W-1:0]   last_idx;
    logic [ACC_W-1:0]   sum_next;
    logic [ACC_W-1:0]   mean;
    logic               complete;
    logic               flush_fire;
    logic [ACC_W-1:0]   block_res;

    // Block control: the first sample of a block sees the live config, later ones the frozen copy.
    always_comb begin
        k_live     = (log2_n > LOG2N_W'(MAX_LOG2_N)) ? LOG2N_W'(MAX_LOG2_N) : log2_n;
        mode_live  = avg_mode_e'(avg_mode);
        blk_open   = (sample_count != '0);
        k_eff      = blk_open ? cfg_k : k_live;
        mode_eff   = blk_open ? cfg_mode : mode_live;
        last_idx   = (CNT_W'(1) << k_eff) - CNT_W'(1);
        sum_next   = acc + (valid_data ? ACC_W'(input_signal) : '0);
        complete   = valid_data && (sample_count == last_idx);
        // Natural completion wins over a coincident flush; empty flush is a no-op.
        flush_fire = flush && !complete && (blk_open || valid_data);
        block_res  = (mode_eff == MODE_MEAN) ? mean : sum_next;
    end

    tdc_round_shift #(
        .ACC_W (ACC_W),
        .K_W   (LOG2N_W)
    ) u_round_shift (
        .din  (sum_next),
        .k    (k_eff),
        .dout (mean)
    );

    // Config tracks the inputs while no block is open and freezes once one starts.
    always_ff @(posedge clk) begin
        if (rst || !blk_open) begin
            cfg_k    <= k_live;
            cfg_mode <= mode_live;
        end
    end

    // Accumulator and sample counter, cleared at every block boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (complete || flush_fire) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (valid_data) begin
            acc          <= sum_next;
            sample_count <= sample_count + CNT_W'(1);
        end
    end

    // Result register and strobe; result and partial flag hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            result         <= '0;
            result_valid   <= 1'b0;
            result_partial <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (complete) begin
                result         <= block_res;
                result_valid   <= 1'b1;
                result_partial <= 1'b0;
            end else if (flush_fire) begin
                result         <= sum_next;
                result_valid   <= 1'b1;
                result_partial <= 1'b1;
            end
        end
    end

endmodule
